unidec_search_ctrl: RTL

- Deterministic scheduler that sequences the code-word prefix/suffix datapath through a complete Sardinas–Patterson search.
- Decides whether a loaded code table is uniquely decipherable.
- It replaces the nondeterministic per-cycle choice of (code select, prefix length) with an exhaustive ordered scan, plus a worklist of dangling suffixes and a visited set.
- It sits beside the code table as the decision engine; it reports ambiguous, decipherable, or overflow.

---
 rtl/unidec_search_ctrl_if.sv | 14 +
 rtl/unidec_search_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/unidec_search_ctrl_if.sv
// unidec_search_ctrl_if: code-table load, start and result bundle of the unique-decipherability search
interface unidec_search_ctrl_if;
    logic        cw_we;
    logic [2:0]  cw_addr;
    logic [15:0] cw_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        ambiguous;
    logic        overflow;
    logic [7:0]  steps;
    modport master (output cw_we, cw_addr, cw_data, start, input busy, done, ambiguous, overflow, steps);
    modport slave (input cw_we, cw_addr, cw_data, start, output busy, done, ambiguous, overflow, steps);
endinterface

// File: rtl/unidec_search_ctrl.sv
// unidec_search_ctrl: deterministic Sardinas-Patterson scheduler deciding unique decipherability of a code table
module unidec_search_ctrl #(
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic rst,
    unidec_search_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = AW + 1;
    typedef enum logic [2:0] {IDLE, SEED, POP, SCAN, DONE} state_t;
    state_t state, nstate;
    logic [15:0] code [8];
    logic [15:0] ent [DEPTH];
    logic [TW-1:0] head, tail;
    logic [7:0] cnt, steps;
    logic [15:0] w, ival, ci, cj;
    logic [1:0] s;
    logic amb, ovf, amb_set, ovf_set, ins, dup, wr, last, idle;
    function automatic logic [4:0] sh(input logic [1:0] n);
        return 5'd3 * ({3'd0, n} + 5'd1);
    endfunction
    function automatic logic [15:0] pfx(input logic [15:0] x, input logic [1:0] n);
        logic [4:0] b;
        b = sh(n);
        return (x >> (b + 5'd1)) != 16'd0 ? (x & ((16'd1 << b) - 16'd1)) | (16'd1 << b) : 16'h7FFF;
    endfunction
    function automatic logic [15:0] sfx(input logic [15:0] x, input logic [1:0] n);
        return x >> sh(n);
    endfunction
    assign idle = state == IDLE || state == DONE;
    assign bus.busy = !idle;
    assign bus.done = state == DONE;
    assign bus.ambiguous = amb;
    assign bus.overflow = ovf;
    assign bus.steps = steps;
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nstate;
    // evaluate the current seed/scan combination and pick the next state
    always_comb begin
        nstate = state;
        amb_set = 1'b0;
        ins = 1'b0;
        ival = '0;
        last = 1'b0;
        dup = 1'b0;
        ci = code[cnt[7:5]];
        cj = code[cnt[4:2]];
        s = cnt[1:0];
        if (state == SEED) begin
            last = cnt == 8'hFF;
            if (ci != 16'd0 && cj != 16'd0 && cnt[7:5] != cnt[4:2]) begin
                if (cnt[7:5] < cnt[4:2] && ci == cj) amb_set = 1'b1;
                else if (pfx(cj, s) == ci) begin
                    ins = 1'b1;
                    ival = sfx(cj, s);
                end
            end
        end else if (state == SCAN) begin
            last = cnt[4:0] == 5'h1F;
            if (cj != 16'd0) begin
                if (s == 2'd0 && cj == w) amb_set = 1'b1;
                else if (cj == pfx(w, s)) begin
                    ins = 1'b1;
                    ival = sfx(w, s);
                end else if (pfx(cj, s) == w) begin
                    ins = 1'b1;
                    ival = sfx(cj, s);
                end
            end
        end
        for (int k = 0; k < DEPTH; k++)
            if (k < int'(tail) && ent[k] == ival) dup = 1'b1;
        ovf_set = ins && !dup && tail == TW'(DEPTH);
        wr = ins && !dup && !ovf_set;
        if (idle) nstate = bus.start ? SEED : state;
        else if (state == POP) nstate = head == tail ? DONE : SCAN;
        else if (amb_set || ovf_set) nstate = DONE;
        else if (last) nstate = POP;
    end
    // code table, worklist/visited array, counters and sticky results
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int k = 0; k < 8; k++) code[k] <= '0;
            for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
            head <= '0;
            tail <= '0;
            cnt <= '0;
            w <= '0;
            steps <= '0;
            amb <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (idle && bus.cw_we) code[bus.cw_addr] <= bus.cw_data;
            cnt <= (state == SEED || state == SCAN) ? cnt + 8'd1 : 8'd0;
            if (idle && bus.start) begin
                head <= '0;
                tail <= '0;
                steps <= '0;
                amb <= 1'b0;
                ovf <= 1'b0;
            end
            if (amb_set) amb <= 1'b1;
            if (ovf_set) ovf <= 1'b1;
            if (wr) begin
                ent[tail[AW-1:0]] <= ival;
                tail <= tail + 1'b1;
            end
            if (state == POP && head != tail) begin
                w <= ent[head[AW-1:0]];
                head <= head + 1'b1;
                steps <= steps + {7'd0, steps != 8'hFF};
            end
        end
endmodule
